// File: rtl/ram_dp_be.sv
// ram_dp_be: dual-port RAM with per-byte write enables on port A and a
// read-only port B. Reads are pipelined (1 or 2 cycles) and tagged by a
// one-cycle valid. After reset a state machine can zero-fill the array
// one word per cycle before the memory reports ready.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   a_address, a_data     port A byte address and write data
//   a_wren                port A per-byte-lane write enables
//   a_rden, a_q, a_valid  port A read request, read data, data-valid strobe
//   b_address, b_rden     port B byte address and read request
//   b_q, b_valid          port B read data and data-valid strobe
//   ready                 high when requests are accepted
module ram_dp_be #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 12,
   parameter int DEPTH          = 1024,
   parameter int READ_LATENCY   = 1,
   parameter int RDW_NEW_DATA   = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [ADDR_WIDTH-1:0]   a_address,
   input  logic [DATA_WIDTH-1:0]   a_data,
   input  logic [DATA_WIDTH/8-1:0] a_wren,
   input  logic                    a_rden,
   output logic [DATA_WIDTH-1:0]   a_q,
   output logic                    a_valid,
   input  logic [ADDR_WIDTH-1:0]   b_address,
   input  logic                    b_rden,
   output logic [DATA_WIDTH-1:0]   b_q,
   output logic                    b_valid,
   output logic                    ready
);
   localparam int LANES     = DATA_WIDTH / 8;
   localparam int LANE_BITS = (LANES > 1) ? $clog2(LANES) : 0;
   localparam int WORD_AW   = ADDR_WIDTH - LANE_BITS;
   localparam int WORD_AW1  = WORD_AW + 1;
   localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [WORD_AW:0] DEPTH_W  = WORD_AW1'(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_CLEAR = 2'd1,
      ST_READY = 2'd2
   } state_t;

   // Overlay the enabled byte lanes of new_word onto old_word.
   function automatic logic [DATA_WIDTH-1:0] merge_lanes(
      input logic [DATA_WIDTH-1:0] old_word,
      input logic [DATA_WIDTH-1:0] new_word,
      input logic [LANES-1:0]      lane_en
   );
      logic [DATA_WIDTH-1:0] res;
      res = old_word;
      for (int i = 0; i < LANES; i++) begin
         if (lane_en[i]) res[8*i +: 8] = new_word[8*i +: 8];
         else            res[8*i +: 8] = old_word[8*i +: 8];
      end
      return res;
   endfunction

   state_t                state_r, state_next_s;
   logic [IDX_W-1:0]      clr_cnt_r;
   logic                  clr_last_s;
   logic                  ready_r;

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [LANES-1:0]      mem_we_s;
   logic [IDX_W-1:0]      mem_wa_s;
   logic [DATA_WIDTH-1:0] mem_wd_s;

   logic [WORD_AW-1:0]    a_word_s, b_word_s;
   logic [IDX_W-1:0]      a_idx_s, b_idx_s;
   logic                  a_in_range_s, b_in_range_s;
   logic                  a_req_s, b_req_s, a_wr_any_s;
   logic [DATA_WIDTH-1:0] a_old_s, b_old_s, a_rd_word_s, b_rd_word_s;

   logic                  a_p1_v_r, b_p1_v_r;
   logic [DATA_WIDTH-1:0] a_p1_d_r, b_p1_d_r;
   logic                  a_src_v_s, b_src_v_s;
   logic [DATA_WIDTH-1:0] a_src_d_s, b_src_d_s;
   logic                  a_valid_r, b_valid_r;
   logic [DATA_WIDTH-1:0] a_q_r, b_q_r;

   // Word address = byte address without the lane-select bits.
   assign a_word_s     = a_address[ADDR_WIDTH-1:LANE_BITS];
   assign b_word_s     = b_address[ADDR_WIDTH-1:LANE_BITS];
   assign a_idx_s      = a_word_s[IDX_W-1:0];
   assign b_idx_s      = b_word_s[IDX_W-1:0];
   assign a_in_range_s = ({1'b0, a_word_s} < DEPTH_W);
   assign b_in_range_s = ({1'b0, b_word_s} < DEPTH_W);

   generate
      if (LANE_BITS > 0) begin : g_lane_bits
         logic unused_low_s;
         assign unused_low_s = ^{a_address[LANE_BITS-1:0], b_address[LANE_BITS-1:0]};
      end
   endgenerate

   assign a_req_s    = ready_r & a_rden;
   assign b_req_s    = ready_r & b_rden;
   assign a_wr_any_s = ready_r & a_in_range_s & (|a_wren);
   assign clr_last_s = (clr_cnt_r == LAST_IDX);

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_r <= ST_RESET;
      else       state_r <= state_next_s;
   end

   // Next-state logic: RESET -> (CLEAR ->) READY.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_RESET: begin
            if (CLEAR_ON_RESET != 0) state_next_s = ST_CLEAR;
            else                     state_next_s = ST_READY;
         end
         ST_CLEAR: begin
            if (clr_last_s) state_next_s = ST_READY;
            else            state_next_s = ST_CLEAR;
         end
         ST_READY: state_next_s = ST_READY;
         default:  state_next_s = ST_RESET;
      endcase
   end

   // Clear counter walks words 0..DEPTH-1 while in CLEAR.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                                      clr_cnt_r <= '0;
      else if ((state_r == ST_CLEAR) && !clr_last_s)  clr_cnt_r <= clr_cnt_r + IDX_ONE;
      else                                            clr_cnt_r <= '0;
   end

   // Registered ready flag, high exactly while the FSM sits in READY.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) ready_r <= 1'b0;
      else       ready_r <= (state_next_s == ST_READY);
   end

   // Write-port mux: clear sequence or port A; out-of-range writes are dropped.
   always_comb begin
      mem_we_s = '0;
      mem_wa_s = '0;
      mem_wd_s = '0;
      if (state_r == ST_CLEAR) begin
         mem_we_s = '1;
         mem_wa_s = clr_cnt_r;
      end else if (ready_r && a_in_range_s) begin
         mem_we_s = a_wren;
         mem_wa_s = a_idx_s;
         mem_wd_s = a_data;
      end else begin
         mem_we_s = '0;
      end
   end

   // Storage array; deliberately not reset so contents survive reset.
   always_ff @(posedge clock) begin
      for (int i = 0; i < LANES; i++) begin
         if (mem_we_s[i]) mem_r[mem_wa_s][8*i +: 8] <= mem_wd_s[8*i +: 8];
      end
   end

   // Read lookup with read-during-write resolution against the port A write.
   always_comb begin
      a_old_s     = mem_r[a_idx_s];
      b_old_s     = mem_r[b_idx_s];
      a_rd_word_s = '0;
      b_rd_word_s = '0;
      if (!a_in_range_s)
         a_rd_word_s = '0;
      else if ((RDW_NEW_DATA != 0) && a_wr_any_s)
         a_rd_word_s = merge_lanes(a_old_s, a_data, a_wren);
      else
         a_rd_word_s = a_old_s;
      if (!b_in_range_s)
         b_rd_word_s = '0;
      else if ((RDW_NEW_DATA != 0) && a_wr_any_s && (b_word_s == a_word_s))
         b_rd_word_s = merge_lanes(b_old_s, a_data, a_wren);
      else
         b_rd_word_s = b_old_s;
   end

   // First pipeline stage, only on the output path when READ_LATENCY is 2.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         a_p1_v_r <= 1'b0;
         b_p1_v_r <= 1'b0;
         a_p1_d_r <= '0;
         b_p1_d_r <= '0;
      end else begin
         a_p1_v_r <= a_req_s;
         b_p1_v_r <= b_req_s;
         if (a_req_s) a_p1_d_r <= a_rd_word_s;
         if (b_req_s) b_p1_d_r <= b_rd_word_s;
      end
   end

   assign a_src_v_s = (READ_LATENCY == 2) ? a_p1_v_r : a_req_s;
   assign b_src_v_s = (READ_LATENCY == 2) ? b_p1_v_r : b_req_s;
   assign a_src_d_s = (READ_LATENCY == 2) ? a_p1_d_r : a_rd_word_s;
   assign b_src_d_s = (READ_LATENCY == 2) ? b_p1_d_r : b_rd_word_s;

   // Output registers: data only loads with a valid result, otherwise holds.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         a_valid_r <= 1'b0;
         b_valid_r <= 1'b0;
         a_q_r     <= '0;
         b_q_r     <= '0;
      end else begin
         a_valid_r <= a_src_v_s;
         b_valid_r <= b_src_v_s;
         if (a_src_v_s) a_q_r <= a_src_d_s;
         if (b_src_v_s) b_q_r <= b_src_d_s;
      end
   end

   assign a_q     = a_q_r;
   assign b_q     = b_q_r;
   assign a_valid = a_valid_r;
   assign b_valid = b_valid_r;
   assign ready   = ready_r;

endmodule

// File: tb/tb_ram_dp_be.sv
// tb_ram_dp_be: checks four ram_dp_be instances (READ_LATENCY 1/2 x
// RDW_NEW_DATA 0/1, DEPTH 16) driven by shared stimulus against a
// timestamped-queue reference model, plus directed vectors and reset sequences.
module tb_ram_dp_be;
   localparam int DW    = 32;
   localparam int AW    = 12;
   localparam int DEPTH = 16;
   localparam int NDUT  = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic [AW-1:0] a_address, b_address;
   logic [DW-1:0] a_data;
   logic [3:0]    a_wren;
   logic          a_rden, b_rden;
   logic [DW-1:0] a_q_w [NDUT];
   logic [DW-1:0] b_q_w [NDUT];
   logic          a_valid_w [NDUT];
   logic          b_valid_w [NDUT];
   logic          ready_w [NDUT];

   always #5 clock = ~clock;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      ram_dp_be #(
         .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
         .READ_LATENCY(g / 2 + 1), .RDW_NEW_DATA(g % 2), .CLEAR_ON_RESET(1)
      ) u_dut (
         .clock(clock), .reset(reset),
         .a_address(a_address), .a_data(a_data), .a_wren(a_wren), .a_rden(a_rden),
         .a_q(a_q_w[g]), .a_valid(a_valid_w[g]),
         .b_address(b_address), .b_rden(b_rden),
         .b_q(b_q_w[g]), .b_valid(b_valid_w[g]),
         .ready(ready_w[g])
      );
   end

   typedef struct { int due; logic [31:0] d; } exp_t;
   typedef struct {
      logic [11:0] aa; logic [31:0] ad; logic [3:0] we; logic ar;
      logic [11:0] ba; logic br; logic chk; logic [31:0] e_old; logic [31:0] e_new;
   } vec_t;

   exp_t        exp_q [2*NDUT][$];
   logic [31:0] last_q [2*NDUT];
   logic [31:0] mem_m [DEPTH];
   int          cycle, rel_cnt;
   bit          ready_m;
   int          n_tests, n_fail;

   task automatic chk(string name, int g, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d: got %h, expected %h (t=%0t)", name, g, act, exp, $time);
      end
   endtask

   task automatic idle();
      a_address = 12'h000; b_address = 12'h000; a_data = 32'h0;
      a_wren = 4'b0000; a_rden = 1'b0; b_rden = 1'b0;
   endtask

   task automatic drive_rand();
      a_address = 12'(($urandom_range(0, 19) << 2) | $urandom_range(0, 3));
      b_address = 12'(($urandom_range(0, 19) << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) b_address = a_address;
      a_data = $urandom;
      a_wren = 4'($urandom);
      a_rden = 1'($urandom);
      b_rden = 1'($urandom);
   endtask

   // One clock: model the edge, then check every DUT output 1 time unit later.
   task automatic tick();
      int wa, wb;
      logic [31:0] old_a, old_b, new_a, new_b, merged;
      exp_t e;
      if (!reset && ready_m) begin
         wa = int'(a_address >> 2);
         wb = int'(b_address >> 2);
         old_a = (wa < DEPTH) ? mem_m[wa] : 32'h0;
         old_b = (wb < DEPTH) ? mem_m[wb] : 32'h0;
         new_a = old_a;
         new_b = old_b;
         merged = old_a;
         if (wa < DEPTH && a_wren != 4'b0000) begin
            for (int i = 0; i < 4; i++)
               if (a_wren[i]) merged[8*i +: 8] = a_data[8*i +: 8];
            new_a = merged;
            if (wb == wa) new_b = merged;
         end
         for (int g = 0; g < NDUT; g++) begin
            e.due = cycle + 1 + (g / 2);
            if (a_rden) begin e.d = (g % 2 == 1) ? new_a : old_a; exp_q[2*g].push_back(e); end
            if (b_rden) begin e.d = (g % 2 == 1) ? new_b : old_b; exp_q[2*g+1].push_back(e); end
         end
         if (wa < DEPTH) mem_m[wa] = merged;
      end
      @(posedge clock);
      cycle++;
      if (reset) begin
         rel_cnt = 0;
         ready_m = 1'b0;
      end else begin
         rel_cnt++;
         if (!ready_m && rel_cnt == DEPTH + 1) begin
            ready_m = 1'b1;
            for (int w = 0; w < DEPTH; w++) mem_m[w] = 32'h0;
         end
      end
      #1;
      for (int g = 0; g < NDUT; g++) begin
         chk("ready", g, {31'b0, ready_w[g]}, {31'b0, ready_m});
         for (int p = 0; p < 2; p++) begin
            int k;
            logic ev;
            k = 2 * g + p;
            ev = 1'b0;
            if (exp_q[k].size() > 0 && exp_q[k][0].due == cycle) begin
               ev = 1'b1;
               last_q[k] = exp_q[k][0].d;
               void'(exp_q[k].pop_front());
            end
            if (p == 0) begin
               chk("a_valid", g, {31'b0, a_valid_w[g]}, {31'b0, ev});
               chk("a_q", g, a_q_w[g], last_q[k]);
            end else begin
               chk("b_valid", g, {31'b0, b_valid_w[g]}, {31'b0, ev});
               chk("b_q", g, b_q_w[g], last_q[k]);
            end
         end
      end
   endtask

   // Assert reset between edges and check outputs clear without a clock edge.
   task automatic reset_async();
      #2 reset = 1'b1;
      #1;
      for (int g = 0; g < NDUT; g++) begin
         chk("async a_q", g, a_q_w[g], 32'h0);
         chk("async b_q", g, b_q_w[g], 32'h0);
         chk("async valid", g, {30'b0, a_valid_w[g], b_valid_w[g]}, 32'h0);
         chk("async ready", g, {31'b0, ready_w[g]}, 32'h0);
      end
      for (int k = 0; k < 2 * NDUT; k++) begin
         exp_q[k].delete();
         last_q[k] = 32'h0;
      end
      ready_m = 1'b0;
      rel_cnt = 0;
   endtask

   // Release reset, keep throwing requests at the blocked memory, measure ready.
   task automatic release_and_wait(string tag);
      int seen [NDUT];
      for (int g = 0; g < NDUT; g++) seen[g] = 0;
      #3 reset = 1'b0;
      for (int e = 1; e <= DEPTH + 3; e++) begin
         if (e <= DEPTH + 1) drive_rand();
         else idle();
         tick();
         for (int g = 0; g < NDUT; g++)
            if (seen[g] == 0 && ready_w[g]) seen[g] = e;
      end
      idle();
      for (int g = 0; g < NDUT; g++) chk(tag, g, seen[g], DEPTH + 1);
   endtask

   task automatic sweep_all();
      for (int w = 0; w < DEPTH; w++) begin
         a_rden = 1'b1; b_rden = 1'b1;
         a_address = 12'(w * 4); b_address = 12'((DEPTH - 1 - w) * 4);
         tick();
      end
      idle();
      repeat (3) tick();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vt [8];
      logic [31:0] pv [4];
      int          cnt [NDUT];
      int          c0;
      logic [31:0] ex;

      vt[0] = '{12'h008, 32'h11223344, 4'b1111, 1'b0, 12'h000, 1'b0, 1'b0, 32'h0, 32'h0};
      vt[1] = '{12'h008, 32'hAABBCCDD, 4'b0101, 1'b0, 12'h000, 1'b0, 1'b0, 32'h0, 32'h0};
      vt[2] = '{12'h008, 32'h0, 4'b0000, 1'b0, 12'h008, 1'b1, 1'b1, 32'h11BB33DD, 32'h11BB33DD};
      vt[3] = '{12'h010, 32'hDEADBEEF, 4'b1111, 1'b0, 12'h000, 1'b0, 1'b0, 32'h0, 32'h0};
      vt[4] = '{12'h010, 32'h12345678, 4'b1111, 1'b1, 12'h010, 1'b1, 1'b1, 32'hDEADBEEF, 32'h12345678};
      vt[5] = '{12'h050, 32'hCAFEF00D, 4'b1111, 1'b0, 12'h000, 1'b0, 1'b0, 32'h0, 32'h0};
      vt[6] = '{12'h050, 32'h0, 4'b0000, 1'b1, 12'h050, 1'b1, 1'b1, 32'h0, 32'h0};
      vt[7] = '{12'h00B, 32'h0, 4'b0000, 1'b1, 12'h009, 1'b1, 1'b1, 32'h11BB33DD, 32'h11BB33DD};
      pv[0] = 32'hA0A0_0001; pv[1] = 32'hB1B1_0002; pv[2] = 32'hC2C2_0003; pv[3] = 32'hD3D3_0004;

      n_tests = 0; n_fail = 0; cycle = 0; rel_cnt = 0; ready_m = 1'b0;
      for (int k = 0; k < 2 * NDUT; k++) last_q[k] = 32'h0;
      for (int w = 0; w < DEPTH; w++) mem_m[w] = 32'h0;
      reset = 1'b1;
      idle();
      tick();
      tick();

      // Clear-fill from power-up, then every word reads back zero.
      release_and_wait("clear ready edge");
      sweep_all();

      // Directed vectors: byte lanes, read-during-write, out of range, low bits.
      for (int v = 0; v < 8; v++) begin
         a_address = vt[v].aa; a_data = vt[v].ad; a_wren = vt[v].we;
         a_rden = vt[v].ar; b_address = vt[v].ba; b_rden = vt[v].br;
         tick();
         idle();
         tick();
         if (vt[v].chk) begin
            for (int g = 0; g < NDUT; g++) begin
               ex = (g % 2 == 1) ? vt[v].e_new : vt[v].e_old;
               if (vt[v].ar) chk($sformatf("vec%0d a_q", v), g, a_q_w[g], ex);
               if (vt[v].br) chk($sformatf("vec%0d b_q", v), g, b_q_w[g], ex);
            end
         end
      end
      sweep_all();

      // Pipelining: four back-to-back port-B reads of words 0..3.
      for (int i = 0; i < 4; i++) begin
         a_address = 12'(i * 4); a_data = pv[i]; a_wren = 4'b1111;
         tick();
      end
      idle();
      tick();
      for (int g = 0; g < NDUT; g++) cnt[g] = 0;
      c0 = cycle + 1;
      for (int i = 0; i < 7; i++) begin
         if (i < 4) begin b_rden = 1'b1; b_address = 12'(i * 4); end
         else idle();
         tick();
         for (int g = 0; g < NDUT; g++) begin
            if (b_valid_w[g]) begin
               if (cnt[g] < 4) begin
                  chk("pipe data", g, b_q_w[g], pv[cnt[g]]);
                  chk("pipe edge", g, cycle, c0 + (g / 2) + cnt[g]);
               end
               cnt[g]++;
            end
         end
      end
      for (int g = 0; g < NDUT; g++) chk("pipe count", g, cnt[g], 4);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 400; i++) begin
         drive_rand();
         tick();
      end
      idle();
      repeat (3) tick();
      sweep_all();

      // Reset with reads in flight: nonzero q clears at once, no stale valid.
      a_rden = 1'b1; b_rden = 1'b1; a_address = 12'h004; b_address = 12'h00C;
      a_data = 32'h0; a_wren = 4'b0000;
      tick();
      a_rden = 1'b1; b_rden = 1'b1; a_address = 12'h000; b_address = 12'h008;
      tick();
      idle();
      reset_async();
      tick();
      tick();
      release_and_wait("ready after in-flight reset");
      sweep_all();

      // Reset aborted at clear count 5, clear restarts from word 0.
      reset_async();
      tick();
      #3 reset = 1'b0;
      repeat (6) begin
         drive_rand();
         tick();
      end
      reset_async();
      tick();
      release_and_wait("ready after clear abort");
      sweep_all();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/ram_dp_be.md
RAM_DP_BE -- requirements
Module: ram_dp_be

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DATA_WIDTH, 32: word width in bits, a multiple of 8; LANES = DATA_WIDTH/8.
- ADDR_WIDTH, 12: byte-address width.
- DEPTH, 1024: number of words, at most 2^(ADDR_WIDTH - log2(LANES)).
- READ_LATENCY, 1: cycles from read request to data; legal values are 1 or 2.
- RDW_NEW_DATA, 0: read-during-write policy for the same word; 0 returns old data, 1 returns new data.
- CLEAR_ON_RESET, 1: when 1, memory is zero-filled after reset.

REQ-002 The block SHALL have these ports (name, direction, width, meaning). Clock and reset are listed first.
- clock, in, 1: the only clock; all logic is on the rising edge.
- reset, in, 1: asynchronous, active-high reset.
- a_address, in, ADDR_WIDTH: port A byte address.
- a_data, in, DATA_WIDTH: port A write data.
- a_wren, in, LANES: port A per-byte write enables.
- a_rden, in, 1: port A read request.
- a_q, out, DATA_WIDTH: port A read data.
- a_valid, out, 1: a_q carries the data for a request.
- b_address, in, ADDR_WIDTH: port B byte address; port B is read-only.
- b_rden, in, 1: port B read request.
- b_q, out, DATA_WIDTH: port B read data.
- b_valid, out, 1: b_q carries the data for a request.
- ready, out, 1: the memory accepts requests.

Function
REQ-003 The word address SHALL be the byte address with its low log2(LANES) bits dropped; those low bits SHALL be ignored.
REQ-004 When ready=1 and a_wren[i]=1 at a rising edge, byte lane i of the addressed word SHALL take a_data[8i+7:8i]; lanes with a_wren[i]=0 SHALL be unchanged.
REQ-005 A read request (x_rden=1 with ready=1) sampled at edge N SHALL produce x_q and x_valid=1 for exactly one cycle after edge N+READ_LATENCY-1. Back-to-back requests SHALL give one result per cycle.
REQ-006 x_q SHALL hold its last value while x_valid=0.
REQ-007 If a read of the same word is sampled at the same edge as a port-A write, both ports SHALL return:
- with RDW_NEW_DATA=0: the pre-write word;
- with RDW_NEW_DATA=1: the post-write word, merged per byte lane.
REQ-008 A word address at or above DEPTH SHALL be handled as follows: a write is discarded; a read returns all zeros with valid asserted at normal latency.
REQ-009 While ready=0, a_wren, a_rden and b_rden SHALL be ignored and no valid SHALL be generated for them.
REQ-010 The block SHALL run a state machine with states RESET, CLEAR and READY:
- RESET is held while reset=1.
- After reset is released, it moves to CLEAR if CLEAR_ON_RESET=1, otherwise to READY, at the first edge.
- CLEAR writes zero to one word per cycle, starting at word 0 and ending at word DEPTH-1, then moves to READY.
- ready=1 only in READY.
REQ-011 With CLEAR_ON_RESET=1, ready SHALL rise exactly DEPTH+1 edges after reset is released.
REQ-012 Reads already in the pipeline SHALL complete normally whatever new requests arrive.

Reset
REQ-013 Asserting reset SHALL immediately force a_q=0, b_q=0, a_valid=0, b_valid=0, ready=0, the clear counter to 0 and all pipeline valid stages to 0, with no clock edge needed.
REQ-014 Reset SHALL NOT modify memory contents itself; only the CLEAR sequence zeroes memory.
REQ-015 Reset asserted during CLEAR SHALL abort the sequence; after release, CLEAR SHALL restart from word 0.
REQ-016 Reset asserted with reads in flight SHALL discard those reads, with no valid pulse after release.

Verification
REQ-017 The bench SHALL cover these directed scenarios, each run with READ_LATENCY=1 and with READ_LATENCY=2:
- Clear-fill: DEPTH=16 and CLEAR_ON_RESET=1, release reset → ready rises at edge 17; a read of every word returns 0.
- Byte lanes: write 0x11223344 with a_wren=4'b1111, then 0xAABBCCDD with a_wren=4'b0101 to byte address 0x8 → a read returns 0x11BB33DD.
- Read-during-write: word holds 0xDEADBEEF; write 0x12345678 with all lanes enabled while both ports read the same address → 0xDEADBEEF with RDW_NEW_DATA=0, 0x12345678 with RDW_NEW_DATA=1.
- Pipelining: 4 back-to-back port-B reads of words 0..3 → 4 consecutive valid cycles with the data in order, starting READ_LATENCY cycles after the first request.
- Out of range: DEPTH=16; write to word 20, then read word 20 → read returns 0 with valid; words 0..15 are unchanged.
- Reset mid-operation: assert reset at clear count 5 → outputs go to 0 asynchronously; after release, ready rises at edge DEPTH+1 again. A read in flight at reset yields no valid pulse.
